// File: rtl/chacha_ks_sequencer_if.sv
// Word-addressed Wishbone-classic bus used for both the host port and the accelerator port.
interface chacha_ks_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/chacha_ks_sequencer.sv
// Keystream sequencer between the host bus and the ChaCha accelerator; streams 16 words per block.
// Optional abort input is enabled by defining CHACHA_SEQ_ABORT_EN.
module chacha_ks_sequencer #(
  parameter logic [3:0]  ADDR_CTRL      = 4'd0,
  parameter logic [3:0]  ADDR_CTR       = 4'd12,
  parameter int unsigned NB_W           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  chacha_ks_sequencer_if.slave  host,
  chacha_ks_sequencer_if.master accel,
  input  logic                  a_irq,
  input  logic                  seq_start,
  input  logic [NB_W-1:0]       seq_nblocks,
  input  logic [31:0]           seq_ctr_init,
`ifdef CHACHA_SEQ_ABORT_EN
  input  logic                  seq_abort,
`endif
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_err,
  output logic [31:0]           ks_data,
  output logic                  ks_valid,
  input  logic                  ks_ready
);

  typedef enum logic [2:0] {
    StIdle, StWrCtr, StWrStart, StWaitIrq, StRdWord, StPush, StNext, StFinish
  } state_e;

  state_e          state;
  logic            m_cyc;
  logic            m_we;
  logic [3:0]      m_adr;
  logic [31:0]     m_dat;
  logic [31:0]     ctr;
  logic [NB_W-1:0] remaining;
  logic [3:0]      idx;
  logic [31:0]     timer;
  logic            pending;
  logic            host_wait;
  logic            new_start;
  logic            accept;
  logic [NB_W-1:0] accept_nb;
  logic            abort_now;

  // Host owns the accelerator only in idle; otherwise it is stalled with no ack.
  always_comb begin
    if (state == StIdle) begin
      accel.cyc   = host.cyc;
      accel.stb   = host.stb;
      accel.we    = host.we;
      accel.adr   = host.adr;
      accel.dat_w = host.dat_w;
      host.ack    = accel.ack;
      host.dat_r  = accel.dat_r;
    end else begin
      accel.cyc   = m_cyc;
      accel.stb   = m_cyc;
      accel.we    = m_we;
      accel.adr   = m_adr;
      accel.dat_w = m_dat;
      host.ack    = 1'b0;
      host.dat_r  = '0;
    end
  end

  assign host_wait = host.cyc & host.stb & ~accel.ack;
  assign new_start = seq_start & ~pending;
  assign accept    = (state == StIdle) & (new_start | pending) & ~host_wait;
  // A pending start already latched its parameters into the working registers.
  assign accept_nb = pending ? remaining : seq_nblocks;

`ifdef CHACHA_SEQ_ABORT_EN
  logic abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else if (state == StIdle || state == StFinish) begin
      abort_q <= 1'b0;
    end else if (seq_abort) begin
      abort_q <= 1'b1;
    end
  end

  assign abort_now = seq_abort | abort_q;
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      m_cyc     <= 1'b0;
      m_we      <= 1'b0;
      m_adr     <= '0;
      m_dat     <= '0;
      ctr       <= '0;
      remaining <= '0;
      idx       <= '0;
      timer     <= '0;
      pending   <= 1'b0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      seq_err   <= 1'b0;
      ks_data   <= '0;
      ks_valid  <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (state == StIdle) begin
        if (new_start) begin
          ctr       <= seq_ctr_init;
          remaining <= seq_nblocks;
          if (host_wait) pending <= 1'b1;
        end
        if (accept) begin
          pending  <= 1'b0;
          seq_busy <= 1'b1;
          seq_err  <= 1'b0;
          idx      <= '0;
          state    <= (accept_nb == '0) ? StFinish : StWrCtr;
        end
      end else if (abort_now && state != StFinish) begin
        // Let an in-flight access finish before giving the bus back.
        if (!m_cyc || accel.ack) begin
          m_cyc    <= 1'b0;
          ks_valid <= 1'b0;
          state    <= StFinish;
        end
      end else begin
        unique case (state)
          StWrCtr: begin
            if (!m_cyc) begin
              m_cyc <= 1'b1;
              m_we  <= 1'b1;
              m_adr <= ADDR_CTR;
              m_dat <= ctr;
            end else if (accel.ack) begin
              m_cyc <= 1'b0;
              state <= StWrStart;
            end
          end
          StWrStart: begin
            if (!m_cyc) begin
              m_cyc <= 1'b1;
              m_we  <= 1'b1;
              m_adr <= ADDR_CTRL;
              m_dat <= 32'h1;
            end else if (accel.ack) begin
              m_cyc <= 1'b0;
              timer <= '0;
              state <= StWaitIrq;
            end
          end
          StWaitIrq: begin
            if (a_irq) begin
              state <= StRdWord;
            end else if (timer == TIMEOUT_CYCLES) begin
              seq_err <= 1'b1;
              state   <= StFinish;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          StRdWord: begin
            if (!m_cyc) begin
              m_cyc <= 1'b1;
              m_we  <= 1'b0;
              m_adr <= idx;
              m_dat <= '0;
            end else if (accel.ack) begin
              m_cyc    <= 1'b0;
              ks_data  <= accel.dat_r;
              ks_valid <= 1'b1;
              state    <= StPush;
            end
          end
          StPush: begin
            if (ks_ready) begin
              ks_valid <= 1'b0;
              idx      <= idx + 4'd1;
              state    <= (idx == 4'd15) ? StNext : StRdWord;
            end
          end
          StNext: begin
            ctr       <= ctr + 32'd1;
            remaining <= remaining - NB_W'(1);
            state     <= (remaining != NB_W'(1)) ? StWrCtr : StFinish;
          end
          StFinish: begin
            seq_done <= 1'b1;
            seq_busy <= 1'b0;
            ks_valid <= 1'b0;
            m_cyc    <= 1'b0;
            state    <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_ks_sequencer.sv
// Randomized bench for chacha_ks_sequencer with an accelerator stub and a keystream reference model.
module tb_chacha_ks_sequencer;
  localparam int unsigned NB_W = 8;
  localparam int unsigned TMO  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            a_irq;
  logic            seq_start = 1'b0;
  logic [NB_W-1:0] seq_nblocks = '0;
  logic [31:0]     seq_ctr_init = '0;
  logic            seq_abort = 1'b0;
  logic            seq_busy, seq_done, seq_err, ks_valid;
  logic [31:0]     ks_data;
  logic            ks_ready = 1'b0;

  chacha_ks_sequencer_if hbus ();
  chacha_ks_sequencer_if abus ();

  always #5 clk = ~clk;

  chacha_ks_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .host         (hbus),
    .accel        (abus),
    .a_irq        (a_irq),
    .seq_start    (seq_start),
    .seq_nblocks  (seq_nblocks),
    .seq_ctr_init (seq_ctr_init),
`ifdef CHACHA_SEQ_ABORT_EN
    .seq_abort    (seq_abort),
`endif
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .ks_data      (ks_data),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Keystream word the stub returns for block counter c at word index i.
  function automatic logic [31:0] ks_word(input logic [31:0] c, input logic [3:0] i);
    return (c * 32'h9E3779B9) ^ ({28'd0, i} * 32'h01000193 + 32'h5A5A0000);
  endfunction

  // ---------------- accelerator stub ----------------
  logic [31:0] mem [16];
  logic [31:0] ctr_reg;
  logic        out_valid;
  int          irq_cnt, irq_dly = 10, ack_delay = 0, wait_cnt;
  int          cyc_cnt = 0, ctrl_ack_cyc = 0;
  logic [36:0] log_q [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    if (reset) begin
      abus.ack   <= 1'b0;
      abus.dat_r <= '0;
      a_irq      <= 1'b0;
      irq_cnt    <= 0;
      wait_cnt   <= 0;
      out_valid  <= 1'b0;
      ctr_reg    <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      abus.ack <= 1'b0;
      if (irq_cnt > 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) begin
          a_irq     <= 1'b1;
          out_valid <= 1'b1;
        end
      end
      if (abus.cyc && abus.stb && !abus.ack) begin
        if (wait_cnt < ack_delay) begin
          wait_cnt <= wait_cnt + 1;
        end else begin
          wait_cnt <= 0;
          abus.ack <= 1'b1;
          log_q.push_back({abus.we, abus.adr, abus.dat_w});
          if (abus.we) begin
            mem[abus.adr] <= abus.dat_w;
            if (abus.adr == 4'd12) ctr_reg <= abus.dat_w;
            if (abus.adr == 4'd0 && abus.dat_w == 32'h1) begin
              a_irq        <= 1'b0;
              out_valid    <= 1'b0;
              irq_cnt      <= irq_dly;
              ctrl_ack_cyc <= cyc_cnt;
            end
          end else begin
            abus.dat_r <= out_valid ? ks_word(ctr_reg, abus.adr) : mem[abus.adr];
          end
        end
      end
    end
  end

  // ---------------- consumer and monitors ----------------
  int          rdy_mode = 0;
  int          done_cnt = 0, done_cyc = 0, stab_err = 0;
  logic [31:0] got [$];
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ks_ready = 1'b1;
      1:       ks_ready = ($urandom_range(0, 2) == 0);
      default: ks_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (seq_done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (prev_v && !prev_r && (!ks_valid || ks_data != prev_d)) stab_err++;
      if (ks_valid && ks_ready) got.push_back(ks_data);
    end
    prev_v = ks_valid && !reset;
    prev_r = ks_ready;
    prev_d = ks_data;
  end

  // ---------------- tasks ----------------
  task automatic host_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd);
    logic acked;
    acked = 1'b0;
    rd    = '0;
    @(posedge clk); #1;
    hbus.cyc = 1'b1; hbus.stb = 1'b1; hbus.we = we; hbus.adr = adr; hbus.dat_w = wd;
    @(negedge clk);
    check("mirror_cyc", abus.cyc, 1'b1);
    check("mirror_adr", abus.adr, adr);
    check("mirror_we", abus.we, we);
    if (we) check("mirror_dat", abus.dat_w, wd);
    for (int c = 0; c < 200; c++) begin
      if (hbus.ack) begin
        rd    = hbus.dat_r;
        acked = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("host_ack", acked, 1'b1);
    @(posedge clk); #1;
    hbus.cyc = 1'b0; hbus.stb = 1'b0; hbus.we = 1'b0;
  endtask

  task automatic clear_obs();
    got.delete();
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input int nb, input logic [31:0] ci);
    @(posedge clk); #1;
    seq_start = 1'b1; seq_nblocks = NB_W'(nb); seq_ctr_init = ci;
    @(posedge clk); #1;
    // Inputs are sampled only with the start pulse.
    seq_start = 1'b0; seq_nblocks = NB_W'($urandom); seq_ctr_init = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", done_cnt != 0, 1);
  endtask

  task automatic check_seq(input int nb, input logic [31:0] ci, input logic exp_err);
    int nw, nctr;
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("busy_idle", seq_busy, 1'b0);
    check("err_flag", seq_err, exp_err);
    nw = exp_err ? 0 : 16 * nb;
    check("word_count", got.size(), nw);
    for (int k = 0; k < nw && k < got.size(); k++)
      check($sformatf("ks_word%0d", k), got[k], ks_word(ci + 32'(k / 16), 4'(k % 16)));
    nctr = 0;
    foreach (log_q[j]) begin
      if (log_q[j][36] && log_q[j][35:32] == 4'd12) begin
        check("ctr_write", log_q[j][31:0], ci + 32'(nctr));
        nctr++;
      end
    end
    check("ctr_write_count", nctr, exp_err ? 1 : nb);
    check("stall_stable", stab_err, 0);
  endtask

  task automatic run_seq(input int nb, input logic [31:0] ci, input int rdy, input logic exp_err);
    rdy_mode = rdy;
    clear_obs();
    pulse_start(nb, ci);
    wait_done(6000);
    check_seq(nb, ci, exp_err);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [31:0] rd, ci;
    int          nb, c;
    hbus.cyc = 1'b0; hbus.stb = 1'b0; hbus.we = 1'b0; hbus.adr = '0; hbus.dat_w = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", seq_busy, 1'b0);
    check("rst_done", seq_done, 1'b0);
    check("rst_err", seq_err, 1'b0);
    check("rst_valid", ks_valid, 1'b0);
    check("rst_data", ks_data, 32'h0);
    check("rst_acyc", abus.cyc, 1'b0);

    // Passthrough write then read-back.
    host_xfer(1'b1, 4'd4, 32'hDEADBEEF, rd);
    host_xfer(1'b0, 4'd4, 32'h0, rd);
    check("pass_read", rd, 32'hDEADBEEF);
    check("pass_busy", seq_busy, 1'b0);

    // Start arrives while a slow host read is outstanding.
    ack_delay = 5;
    rdy_mode  = 0;
    clear_obs();
    ci = $urandom;
    fork
      host_xfer(1'b0, 4'd4, 32'h0, rd);
      begin
        repeat (2) @(posedge clk);
        #1 seq_start = 1'b1; seq_nblocks = NB_W'(1); seq_ctr_init = ci;
        @(posedge clk);
        #1 seq_start = 1'b0; seq_nblocks = '0; seq_ctr_init = '0;
      end
    join
    check("pend_host_read", rd, 32'hDEADBEEF);
    wait_done(6000);
    check("pend_first_host", {27'd0, log_q[0][36:32]}, {27'd0, 1'b0, 4'd4});
    check("pend_then_ctr", {27'd0, log_q[1][36:32]}, {27'd0, 1'b1, 4'd12});
    check_seq(1, ci, 1'b0);
    ack_delay = 0;

    // Counter wrap across two blocks, then stalled consumer.
    run_seq(2, 32'hFFFFFFFF, 0, 1'b0);
    run_seq(3, $urandom, 1, 1'b0);
    for (int t = 0; t < 3; t++) begin
      nb = $urandom_range(1, 3);
      run_seq(nb, $urandom, $urandom_range(0, 1), 1'b0);
    end

    // Zero blocks: no accelerator traffic at all.
    run_seq(0, $urandom, 0, 1'b0);
    check("zero_no_access", log_q.size(), 0);

    // Interrupt never arrives.
    irq_dly = -1;
    run_seq(1, $urandom, 0, 1'b1);
    check("timeout_window", (done_cyc - ctrl_ack_cyc) inside {[14:24]}, 1);
    irq_dly = 10;
    run_seq(1, $urandom, 1, 1'b0);

    // Reset while a word is held in PUSH.
    clear_obs();
    rdy_mode = 2;
    pulse_start(2, $urandom);
    c = 0;
    while (!ks_valid && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("push_reached", ks_valid, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", ks_valid, 1'b0);
    check("rst_mid_acyc", abus.cyc, 1'b0);
    check("rst_mid_busy", seq_busy, 1'b0);
    reset = 1'b0;
    run_seq(1, $urandom, 0, 1'b0);

`ifdef CHACHA_SEQ_ABORT_EN
    // Abort while waiting for the interrupt.
    irq_dly  = -1;
    rdy_mode = 0;
    clear_obs();
    pulse_start(1, $urandom);
    c = 0;
    while (log_q.size() < 2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    #1 seq_abort = 1'b1;
    @(posedge clk); #1 seq_abort = 1'b0;
    wait_done(50);
    repeat (2) @(negedge clk);
    check("abort_err", seq_err, 1'b0);
    check("abort_busy", seq_busy, 1'b0);
    check("abort_words", got.size(), 0);
    irq_dly = 10;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
